// File: rtl/vram_bus_pkg.sv
// Shared widths and the transfer state encoding for the video memory bus master.
package vram_bus_pkg;

    localparam int DATA_WIDTH      = 8;
    localparam int ADDRESS_WIDTH   = 23;
    localparam int CORE_WIDTH      = 16;
    localparam int WORD_ADDR_WIDTH = ADDRESS_WIDTH - 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        TURN,
        RD_LO,
        RD_HI,
        DONE
    } state_t;

endpackage

// File: rtl/vram_bus_master_if.sv
// Core-side request/response channel of the video memory bus master.
// Build option: VRAM_BYTE_ACCESS_EN adds core_byte/core_bsel.
interface vram_bus_master_if;
    import vram_bus_pkg::*;

    logic                       core_req;
    logic                       core_we;
    logic [WORD_ADDR_WIDTH-1:0] core_addr;
    logic [CORE_WIDTH-1:0]      core_wdata;
    logic                       core_ready;
    logic                       core_rvalid;
    logic [CORE_WIDTH-1:0]      core_rdata;

`ifdef VRAM_BYTE_ACCESS_EN
    logic                       core_byte;
    logic                       core_bsel;

    modport master (
        output core_req, core_we, core_addr, core_wdata, core_byte, core_bsel,
        input  core_ready, core_rvalid, core_rdata
    );
    modport slave (
        input  core_req, core_we, core_addr, core_wdata, core_byte, core_bsel,
        output core_ready, core_rvalid, core_rdata
    );
`else
    modport master (
        output core_req, core_we, core_addr, core_wdata,
        input  core_ready, core_rvalid, core_rdata
    );
    modport slave (
        input  core_req, core_we, core_addr, core_wdata,
        output core_ready, core_rvalid, core_rdata
    );
`endif

endinterface

// File: rtl/vram_tristate_pad.sv
// Sole driver of the shared byte bus: drives tx_byte while enabled, otherwise releases to high-Z.
module vram_tristate_pad
    import vram_bus_pkg::*;
(
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_byte,
    output logic [DATA_WIDTH-1:0] rx_byte,
    inout  wire  [DATA_WIDTH-1:0] data
);

    assign data    = enable ? tx_byte : {DATA_WIDTH{1'bz}};
    assign rx_byte = data;

endmodule

// File: rtl/vram_bus_master.sv
// Bridges 16-bit core transfers onto an 8-bit video memory bus as low/high byte phases.
// Build option: VRAM_BYTE_ACCESS_EN adds single-byte transfers selected by core_byte/core_bsel.
module vram_bus_master
    import vram_bus_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                     clock_reference,
    input  logic                     clock_reset,
    vram_bus_master_if.slave         core,
    output logic                     wren,
    output logic [ADDRESS_WIDTH-1:0] adress,
    inout  wire  [DATA_WIDTH-1:0]    data
);

    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    state_t                state, state_next;
    logic [1:0]            lat_cnt;
    logic [CORE_WIDTH-1:0] wdata_q;
    logic [CORE_WIDTH-1:0] rdata_q;
    logic                  single_q;
    logic                  req_single;
    logic                  req_bsel;
    logic                  accept;
    logic                  phase_end;
    logic [DATA_WIDTH-1:0] tx_byte;
    logic [DATA_WIDTH-1:0] rx_byte;

`ifdef VRAM_BYTE_ACCESS_EN
    assign req_single = core.core_byte;
    assign req_bsel   = core.core_byte & core.core_bsel;
`else
    assign req_single = 1'b0;
    assign req_bsel   = 1'b0;
`endif

    assign accept    = core.core_req && (state == IDLE);
    assign phase_end = (lat_cnt == 2'd0);

    always_ff @(posedge clock_reference or posedge clock_reset) begin
        if (clock_reset) state <= IDLE;
        else             state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (core.core_req) state_next = core.core_we ? WR_LO : RD_LO;
            WR_LO:   state_next = single_q ? TURN : WR_HI;
            WR_HI:   state_next = TURN;
            TURN:    state_next = IDLE;
            RD_LO:   if (phase_end) state_next = single_q ? DONE : RD_HI;
            RD_HI:   if (phase_end) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wren             = (state == WR_LO) || (state == WR_HI);
        tx_byte          = (state == WR_HI) ? wdata_q[CORE_WIDTH-1:DATA_WIDTH]
                                            : wdata_q[DATA_WIDTH-1:0];
        core.core_ready  = (state == IDLE);
        core.core_rvalid = (state == DONE);
        core.core_rdata  = rdata_q;
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_reference or posedge clock_reset) begin
        if (clock_reset) begin
            adress   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            lat_cnt  <= '0;
            single_q <= 1'b0;
        end else if (accept) begin
            // Inputs are captured here; the core may change them freely afterwards.
            adress   <= {core.core_addr, req_bsel};
            wdata_q  <= core.core_wdata;
            single_q <= req_single;
            lat_cnt  <= LAT_LOAD;
        end else if (state == WR_LO && !single_q) begin
            adress[0] <= 1'b1;
        end else if (state == RD_LO || state == RD_HI) begin
            if (!phase_end) begin
                lat_cnt <= lat_cnt - 2'd1;
            end else begin
                lat_cnt <= LAT_LOAD;
                if (state == RD_LO) begin
                    rdata_q[DATA_WIDTH-1:0] <= rx_byte;
                    if (single_q) rdata_q[CORE_WIDTH-1:DATA_WIDTH] <= '0;
                    else          adress[0] <= 1'b1;
                end else begin
                    rdata_q[CORE_WIDTH-1:DATA_WIDTH] <= rx_byte;
                end
            end
        end
    end

    vram_tristate_pad u_pad (
        .enable  (wren),
        .tx_byte (tx_byte),
        .rx_byte (rx_byte),
        .data    (data)
    );

endmodule

// File: tb/tb_vram_bus_master.sv
// Scoreboard bench: instance a runs READ_LATENCY=1, instance b runs READ_LATENCY=3.
// Build option: VRAM_BYTE_ACCESS_EN enables the byte-transfer vectors.
module tb_vram_bus_master;
    import vram_bus_pkg::*;

    typedef struct { logic [22:0] adr; logic [7:0] dat; int due; } bus_exp_t;
    typedef struct { logic [15:0] rdata; int due; } rd_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vram_bus_master_if if_a ();
    vram_bus_master_if if_b ();
    logic        wren_a, wren_b;
    logic [22:0] adress_a, adress_b;
    wire  [7:0]  data_a, data_b;

    vram_bus_master #(.READ_LATENCY(1)) dut_a (
        .clock_reference (clk), .clock_reset (rst), .core (if_a.slave),
        .wren (wren_a), .adress (adress_a), .data (data_a)
    );
    vram_bus_master #(.READ_LATENCY(3)) dut_b (
        .clock_reference (clk), .clock_reset (rst), .core (if_b.slave),
        .wren (wren_b), .adress (adress_b), .data (data_b)
    );

    // Sparse memory models: only the handful of addresses the vectors touch are distinct.
    logic [7:0]  mem_a [0:255];
    logic [7:0]  mem_b [0:255];
    logic [7:0]  q_a = 8'h00;
    logic [7:0]  q_b = 8'h00;
    logic [22:0] pipe_b1 = '0;
    logic [22:0] pipe_b2 = '0;

    function automatic logic [7:0] idx(input logic [22:0] a);
        return {a[22], a[9], a[5:0]};
    endfunction

    initial for (int i = 0; i < 256; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end

    assign data_a = wren_a ? 8'hzz : q_a;
    assign data_b = wren_b ? 8'hzz : q_b;

    always @(negedge clk) begin
        if (wren_a) mem_a[idx(adress_a)] <= data_a;
        q_a <= mem_a[idx(adress_a)];
    end

    // Latency 3: the byte for an address appears only once it has been held for three cycles.
    always @(negedge clk) begin
        if (wren_b) mem_b[idx(adress_b)] <= data_b;
        pipe_b1 <= adress_b;
        pipe_b2 <= pipe_b1;
        q_b     <= mem_b[idx(pipe_b2)];
    end

    bus_exp_t wq_a[$], wq_b[$];
    rd_exp_t  rq_a[$], rq_b[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic monitor_step(input int inst, input logic wr, input logic [22:0] adr,
                                input logic [7:0] dat, input logic rv, input logic [15:0] rdat);
        bus_exp_t be;
        rd_exp_t  re;
        int       n_wr, n_rd;
        n_wr = (inst == 0) ? wq_a.size() : wq_b.size();
        n_rd = (inst == 0) ? rq_a.size() : rq_b.size();
        if (wr) begin
            if (n_wr == 0) check($sformatf("i%0d_spurious_wren", inst), 32'(wr), 32'd0);
            else begin
                if (inst == 0) be = wq_a.pop_front(); else be = wq_b.pop_front();
                check($sformatf("i%0d_wr_adress", inst), 32'(adr), 32'(be.adr));
                check($sformatf("i%0d_wr_data", inst), 32'(dat), 32'(be.dat));
                check($sformatf("i%0d_wr_cycle", inst), cyc, be.due);
            end
        end
        if (rv) begin
            if (n_rd == 0) check($sformatf("i%0d_spurious_rvalid", inst), 32'(rv), 32'd0);
            else begin
                if (inst == 0) re = rq_a.pop_front(); else re = rq_b.pop_front();
                check($sformatf("i%0d_rdata", inst), 32'(rdat), 32'(re.rdata));
                check($sformatf("i%0d_rvalid_cycle", inst), cyc, re.due);
            end
        end
    endtask

    always @(negedge clk) monitor_step(0, wren_a, adress_a, data_a, if_a.core_rvalid, if_a.core_rdata);
    always @(negedge clk) monitor_step(1, wren_b, adress_b, data_b, if_b.core_rvalid, if_b.core_rdata);

    function automatic logic ready_of(input int inst);
        return (inst == 0) ? if_a.core_ready : if_b.core_ready;
    endfunction

    task automatic drive(input int inst, input logic req, input logic we,
                         input logic [21:0] addr, input logic [15:0] wdata);
        if (inst == 0) begin
            if_a.core_req = req; if_a.core_we = we; if_a.core_addr = addr; if_a.core_wdata = wdata;
        end else begin
            if_b.core_req = req; if_b.core_we = we; if_b.core_addr = addr; if_b.core_wdata = wdata;
        end
    endtask

    // Called at a negedge; returns at the negedge after the acceptance edge with acc = that edge.
    task automatic issue(input int inst, input logic we, input logic [21:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp_rdata,
                         input logic single, input logic bsel, output int acc);
        int n = 0;
        int lat = (inst == 0) ? 1 : 3;
        while (!ready_of(inst) && n < 64) begin @(negedge clk); n++; end
        check($sformatf("i%0d_ready_before_issue", inst), 32'(ready_of(inst)), 32'd1);
        drive(inst, 1'b1, we, addr, wdata);
`ifdef VRAM_BYTE_ACCESS_EN
        if (inst == 0) begin if_a.core_byte = single; if_a.core_bsel = bsel; end
        else           begin if_b.core_byte = single; if_b.core_bsel = bsel; end
`endif
        acc = cyc + 1;
        if (we) begin
            if (single) begin
                if (inst == 0) wq_a.push_back('{{addr, bsel}, wdata[7:0], acc});
                else           wq_b.push_back('{{addr, bsel}, wdata[7:0], acc});
            end else if (inst == 0) begin
                wq_a.push_back('{{addr, 1'b0}, wdata[7:0], acc});
                wq_a.push_back('{{addr, 1'b1}, wdata[15:8], acc + 1});
            end else begin
                wq_b.push_back('{{addr, 1'b0}, wdata[7:0], acc});
                wq_b.push_back('{{addr, 1'b1}, wdata[15:8], acc + 1});
            end
        end else if (inst == 0) rq_a.push_back('{exp_rdata, acc + (single ? lat : 2 * lat)});
        else                    rq_b.push_back('{exp_rdata, acc + (single ? lat : 2 * lat)});
        @(negedge clk);
        drive(inst, 1'b0, ~we, ~addr, ~wdata);
    endtask

    task automatic expect_ready(input int inst, input string name, input int due);
        int n = 0;
        while (!ready_of(inst) && n < 64) begin @(negedge clk); n++; end
        check(name, cyc, due);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
`ifdef VRAM_BYTE_ACCESS_EN
        if_a.core_byte = 1'b0; if_a.core_bsel = 1'b0;
        if_b.core_byte = 1'b0; if_b.core_bsel = 1'b0;
`endif
        #2;
        check("reset_wren", 32'(wren_a), 32'd0);
        check("reset_adress", 32'(adress_a), 32'd0);
        check("reset_rvalid", 32'(if_a.core_rvalid), 32'd0);
        check("reset_rdata", 32'(if_a.core_rdata), 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(if_a.core_ready), 32'd1);

        // Word write; a request raised while busy must be ignored.
        issue(0, 1'b1, 22'h000005, 16'hA55A, 16'h0000, 1'b0, 1'b0, acc);
        drive(0, 1'b1, 1'b1, 22'h2AAAAA, 16'hFFFF);
        @(negedge clk); @(negedge clk);
        drive(0, 1'b0, 1'b0, 22'h000000, 16'h0000);
        expect_ready(0, "wr_ready_cycle", acc + 3);

        // Back-to-back read of the same word.
        issue(0, 1'b0, 22'h000005, 16'h0000, 16'hA55A, 1'b0, 1'b0, acc);
        expect_ready(0, "rd_ready_cycle", acc + 3);

        // Top word address, and read data must survive the write.
        issue(0, 1'b1, 22'h3FFFFF, 16'h1234, 16'h0000, 1'b0, 1'b0, acc);
        expect_ready(0, "max_wr_ready_cycle", acc + 3);
        check("rdata_hold_over_write", 32'(if_a.core_rdata), 32'h0000A55A);
        issue(0, 1'b0, 22'h3FFFFF, 16'h0000, 16'h1234, 1'b0, 1'b0, acc);
        expect_ready(0, "max_rd_ready_cycle", acc + 3);

        // Reset pulse during WR_HI: only the low byte ever reaches the bus.
        issue(0, 1'b1, 22'h000100, 16'hBEEF, 16'h0000, 1'b0, 1'b0, acc);
        void'(wq_a.pop_back());
        @(posedge clk); #2 rst = 1'b1; #1;
        check("midreset_wren", 32'(wren_a), 32'd0);
        check("midreset_adress", 32'(adress_a), 32'd0);
        check("midreset_rvalid", 32'(if_a.core_rvalid), 32'd0);
        check("midreset_rdata", 32'(if_a.core_rdata), 32'd0);
        @(negedge clk); @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        check("ready_after_pulse", 32'(if_a.core_ready), 32'd1);
        issue(0, 1'b1, 22'h000100, 16'hC0DE, 16'h0000, 1'b0, 1'b0, acc);
        expect_ready(0, "post_reset_wr_ready", acc + 3);
        issue(0, 1'b0, 22'h000100, 16'h0000, 16'hC0DE, 1'b0, 1'b0, acc);
        expect_ready(0, "post_reset_rd_ready", acc + 3);

`ifdef VRAM_BYTE_ACCESS_EN
        issue(0, 1'b1, 22'h000005, 16'hEE77, 16'h0000, 1'b1, 1'b0, acc);
        expect_ready(0, "byte_wr_ready", acc + 2);
        issue(0, 1'b0, 22'h000005, 16'h0000, 16'hA577, 1'b0, 1'b0, acc);
        expect_ready(0, "word_after_byte_ready", acc + 3);
        issue(0, 1'b0, 22'h3FFFFF, 16'h0000, 16'h0012, 1'b1, 1'b1, acc);
        expect_ready(0, "byte_rd_ready", acc + 2);
`endif

        // Latency-3 instance: each byte address is held for three cycles.
        issue(1, 1'b1, 22'h000005, 16'hA55A, 16'h0000, 1'b0, 1'b0, acc);
        expect_ready(1, "lat3_wr_ready", acc + 3);
        issue(1, 1'b0, 22'h000005, 16'h0000, 16'hA55A, 1'b0, 1'b0, acc);
        expect_ready(1, "lat3_rd_ready", acc + 7);

        repeat (4) @(negedge clk);
        check("i0_wr_pending", wq_a.size(), 32'd0);
        check("i0_rd_pending", rq_a.size(), 32'd0);
        check("i1_wr_pending", wq_b.size(), 32'd0);
        check("i1_rd_pending", rq_b.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
